// File: rtl/top_fdct_pkg.sv
// Shared widths and types for the FDCT multiply / accumulate / descale path.
package top_fdct_pkg;

  localparam int FDCT_PROD_W     = 29;
  localparam int FDCT_TAPS       = 8;
  localparam int FDCT_CONST_BITS = 13;
  localparam int FDCT_COEF_W     = 16;
  localparam int FDCT_ACC_W      = FDCT_PROD_W + $clog2(FDCT_TAPS);

  typedef logic signed [FDCT_PROD_W-1:0] prod_t;
  typedef logic signed [FDCT_ACC_W-1:0]  acc_t;
  typedef logic signed [FDCT_COEF_W-1:0] coef_t;

endpackage

// File: rtl/top_fdct_descale_sat.sv
// Combinational round-half-up, arithmetic descale and signed saturation.
// Shared between the row and column passes of the FDCT.
module top_fdct_descale_sat
  import top_fdct_pkg::*;
#(
  parameter int ACC_W = FDCT_ACC_W,
  parameter int SHIFT = FDCT_CONST_BITS,
  parameter int OUT_W = FDCT_COEF_W
) (
  input  logic [ACC_W-1:0] i_sum,
  output logic [OUT_W-1:0] o_data,
  output logic             o_sat
);

  // One extra bit of headroom so the rounding add can never wrap.
  localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0] w_sumExt;
  logic signed [ACC_W:0] w_rnd;
  logic signed [ACC_W:0] w_shr;

  assign w_sumExt = {i_sum[ACC_W-1], i_sum};
  assign w_rnd    = w_sumExt + HALF;
  assign w_shr    = w_rnd >>> SHIFT;

  always_comb begin
    o_data = w_shr[OUT_W-1:0];
    o_sat  = 1'b0;
    if (w_shr > MAXV) begin
      o_data = {1'b0, {(OUT_W-1){1'b1}}};
      o_sat  = 1'b1;
    end else if (w_shr < MINV) begin
      o_data = {1'b1, {(OUT_W-1){1'b0}}};
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/top_fdct_mac_descale_8tap.sv
// Accumulates N_TAPS signed products into one DCT coefficient, then rounds,
// descales and saturates it into a valid/ready output register.
module top_fdct_mac_descale_8tap
  import top_fdct_pkg::*;
#(
  parameter int IN_W   = FDCT_PROD_W,
  parameter int N_TAPS = FDCT_TAPS,
  parameter int SHIFT  = FDCT_CONST_BITS,
  parameter int OUT_W  = FDCT_COEF_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_clear,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int ACC_W = IN_W + $clog2(N_TAPS);
  localparam int CNT_W = $clog2(N_TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_tapCnt;
  logic [OUT_W-1:0]        r_outData;
  logic                    r_outSat;
  logic                    r_outValid;

  logic                    w_lastTap;
  logic                    w_accept;
  logic                    w_close;
  logic signed [ACC_W-1:0] w_inExt;
  logic signed [ACC_W-1:0] w_sum;
  logic [OUT_W-1:0]        w_coef;
  logic                    w_coefSat;

  // Only the closing tap needs room in the output register.
  assign w_lastTap = (r_tapCnt == LAST_TAP);
  assign in_ready  = !w_lastTap || !r_outValid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_close   = w_accept && w_lastTap && !in_clear;

  assign w_inExt = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign w_sum   = r_acc + w_inExt;

  top_fdct_descale_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_descale (
    .i_sum  (w_sum),
    .o_data (w_coef),
    .o_sat  (w_coefSat)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_acc    <= '0;
      r_tapCnt <= '0;
    end else if (in_clear) begin
      r_acc    <= '0;
      r_tapCnt <= '0;
    end else if (w_accept) begin
      if (w_lastTap) begin
        r_acc    <= '0;
        r_tapCnt <= '0;
      end else begin
        r_acc    <= w_sum;
        r_tapCnt <= r_tapCnt + CNT_W'(1);
      end
    end
  end

  // A closing tap and a drain in the same cycle reload without a bubble.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_outData  <= '0;
      r_outSat   <= 1'b0;
      r_outValid <= 1'b0;
    end else if (w_close) begin
      r_outData  <= w_coef;
      r_outSat   <= w_coefSat;
      r_outValid <= 1'b1;
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_data  = r_outData;
  assign out_sat   = r_outSat;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_top_fdct_mac_descale_8tap.sv
// Directed self-checking bench for the 8-tap FDCT accumulate/descale block.
module tb_top_fdct_mac_descale_8tap;

  logic        clk;
  logic        rst;
  logic        inClear;
  logic [28:0] inData;
  logic        inValid;
  logic        inReady;
  logic [15:0] outData;
  logic        outSat;
  logic        outValid;
  logic        outReady;

  int checks;
  int failures;

  top_fdct_mac_descale_8tap dut (
    .ap_clk    (clk),
    .ap_rst    (rst),
    .in_clear  (inClear),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .out_data  (outData),
    .out_sat   (outSat),
    .out_valid (outValid),
    .out_ready (outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one product and waits (bounded) until it is accepted.
  task automatic applyStimulus(input logic [28:0] d);
    inData  = d;
    inValid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !inReady; i++) tick();
    checkOutput("tap_ready", inReady, 1);
    tick();
    inValid = 1'b0;
  endtask

  task automatic sendRepeat(input logic [28:0] d, input int n);
    for (int i = 0; i < n; i++) applyStimulus(d);
  endtask

  task automatic roundCase(input string tag, input logic [28:0] d, input int expected);
    applyStimulus(d);
    sendRepeat(29'h0, 7);
    checkOutput({tag, "_valid"}, outValid, 1);
    checkOutput({tag, "_data"}, $signed(outData), expected);
    checkOutput({tag, "_sat"}, outSat, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    inClear  = 1'b0;
    inData   = '0;
    inValid  = 1'b0;
    outReady = 1'b1;
    $display("[TB] reset");
    tick();
    tick();
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_data", $signed(outData), 0);
    checkOutput("rst_sat", outSat, 0);
    rst = 1'b0;
    tick();
    checkOutput("rst_in_ready", inReady, 1);

    $display("[TB] basic group");
    sendRepeat(29'h2000, 7);
    checkOutput("t1_early_valid", outValid, 0);
    applyStimulus(29'h2000);
    checkOutput("t1_valid", outValid, 1);
    checkOutput("t1_data", $signed(outData), 8);
    checkOutput("t1_sat", outSat, 0);
    tick();
    checkOutput("t1_drained", outValid, 0);

    $display("[TB] rounding");
    roundCase("r_p4096", 29'h1000, 1);
    roundCase("r_p4095", 29'h0FFF, 0);
    roundCase("r_m4096", 29'h1FFFF000, 0);
    roundCase("r_m4097", 29'h1FFFEFFF, -1);

    $display("[TB] saturation");
    sendRepeat(29'h0FFFFFFF, 8);
    checkOutput("sat_hi_data", $signed(outData), 32767);
    checkOutput("sat_hi_sat", outSat, 1);
    sendRepeat(29'h10000000, 8);
    checkOutput("sat_lo_data", $signed(outData), -32768);
    checkOutput("sat_lo_sat", outSat, 1);
    tick();
    checkOutput("sat_drained", outValid, 0);

    $display("[TB] backpressure");
    outReady = 1'b0;
    sendRepeat(29'h2000, 8);
    checkOutput("bp_first_valid", outValid, 1);
    checkOutput("bp_first_data", $signed(outData), 8);
    sendRepeat(29'h2000, 7);
    checkOutput("bp_hold_data", $signed(outData), 8);
    checkOutput("bp_hold_valid", outValid, 1);
    inData  = 29'h2000;
    inValid = 1'b1;
    #1;
    checkOutput("bp_stall", inReady, 0);
    tick();
    checkOutput("bp_stall2", inReady, 0);
    checkOutput("bp_stable_data", $signed(outData), 8);
    checkOutput("bp_stable_sat", outSat, 0);
    outReady = 1'b1;
    #1;
    checkOutput("bp_release_ready", inReady, 1);
    tick();
    inValid = 1'b0;
    checkOutput("bp_second_valid", outValid, 1);
    checkOutput("bp_second_data", $signed(outData), 8);
    tick();
    checkOutput("bp_no_dup", outValid, 0);

    $display("[TB] clear");
    sendRepeat(29'h2000, 3);
    inClear = 1'b1;
    inData  = 29'h2000;
    inValid = 1'b1;
    tick();
    inClear = 1'b0;
    inValid = 1'b0;
    sendRepeat(29'h2000, 7);
    checkOutput("clr_early_valid", outValid, 0);
    applyStimulus(29'h2000);
    checkOutput("clr_valid", outValid, 1);
    checkOutput("clr_data", $signed(outData), 8);
    tick();
    outReady = 1'b0;
    sendRepeat(29'h0FFFFFFF, 8);
    sendRepeat(29'h2000, 2);
    inClear = 1'b1;
    tick();
    inClear = 1'b0;
    checkOutput("clr_pend_valid", outValid, 1);
    checkOutput("clr_pend_data", $signed(outData), 32767);
    checkOutput("clr_pend_sat", outSat, 1);
    outReady = 1'b1;
    tick();
    checkOutput("clr_pend_drained", outValid, 0);
    sendRepeat(29'h2000, 7);
    checkOutput("clr2_early_valid", outValid, 0);
    applyStimulus(29'h2000);
    checkOutput("clr2_data", $signed(outData), 8);
    tick();

    $display("[TB] async reset");
    outReady = 1'b0;
    sendRepeat(29'h0FFFFFFF, 8);
    checkOutput("ar_pend_sat", outSat, 1);
    sendRepeat(29'h2000, 3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", outValid, 0);
    checkOutput("ar_data", $signed(outData), 0);
    checkOutput("ar_sat", outSat, 0);
    tick();
    rst      = 1'b0;
    outReady = 1'b1;
    sendRepeat(29'h2000, 7);
    checkOutput("ar_early_valid", outValid, 0);
    applyStimulus(29'h2000);
    checkOutput("ar_post_valid", outValid, 1);
    checkOutput("ar_post_data", $signed(outData), 8);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
